// File: rtl/modexp_pkg.sv
// Shared types and sizing for the modular-exponentiation sequencer.
package modexp_pkg;

    localparam int WIDTH_DEF     = 128;
    localparam int EXP_WIDTH_DEF = 128;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        FINISH
    } state_e;

    // One spare bit so a bit index of EXP_WIDTH itself is representable.
    function automatic int idx_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/modexp_ctrl_msb_find.sv
// Combinational priority encoder: index of the highest set bit and an all-zero flag.
module msb_find
    import modexp_pkg::*;
#(
    parameter  int W     = EXP_WIDTH_DEF,
    localparam int IDX_W = idx_width(W)
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             zero_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        zero_o = ~|vec_i;
    end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external modular multiplier.
// Optional MODEXP_PERF_CNT_EN adds the mm_ops multiplier-launch counter output.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_n,
    input  logic                 mm_done,
    input  logic [WIDTH-1:0]     mm_r
`ifdef MODEXP_PERF_CNT_EN
    ,
    output logic [15:0]          mm_ops
`endif
);

    localparam int IDX_W = idx_width(EXP_WIDTH);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     base_q, base_d, mod_q, mod_d, acc_q, acc_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [IDX_W-1:0]     bit_q, bit_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d, error_q, error_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 mm_start_q, mm_start_d;
    logic [WIDTH-1:0]     mm_a_q, mm_a_d, mm_b_q, mm_b_d, mm_n_q, mm_n_d;
    logic [IDX_W-1:0]     msb_idx;
    logic                 exp_zero;
    logic                 exp_bit;
    logic                 mm_ack;

    msb_find #(.W(EXP_WIDTH)) u_msb_find (
        .vec_i  (exp_q),
        .idx_o  (msb_idx),
        .zero_o (exp_zero)
    );

    assign exp_bit = |(exp_q & (EXP_WIDTH'(1) << bit_q));
    // A completion in the launch cycle belongs to no operation we are waiting on.
    assign mm_ack  = mm_done && !mm_start_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        exp_d      = exp_q;
        mod_d      = mod_q;
        acc_d      = acc_q;
        bit_d      = bit_q;
        err_d      = err_q;
        done_d     = 1'b0;
        error_d    = error_q;
        result_d   = result_q;
        mm_start_d = 1'b0;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_n_d     = mm_n_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base;
                    exp_d  = exponent;
                    mod_d  = modulus;
                    if (modulus == '0 || base >= modulus) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        state_d = FINISH;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (exp_zero) begin
                    acc_d   = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    state_d = FINISH;
                end else begin
                    acc_d   = base_q;
                    bit_d   = msb_idx;
                    state_d = (msb_idx == '0) ? FINISH : SQ_ISSUE;
                end
            end
            SQ_ISSUE: begin
                mm_a_d     = acc_q;
                mm_b_d     = acc_q;
                mm_n_d     = mod_q;
                mm_start_d = 1'b1;
                bit_d      = bit_q - IDX_W'(1);
                state_d    = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (mm_ack) begin
                    acc_d = mm_r;
                    if (exp_bit)            state_d = MUL_ISSUE;
                    else if (bit_q == '0)   state_d = FINISH;
                    else                    state_d = SQ_ISSUE;
                end
            end
            MUL_ISSUE: begin
                mm_a_d     = acc_q;
                mm_b_d     = base_q;
                mm_n_d     = mod_q;
                mm_start_d = 1'b1;
                state_d    = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mm_ack) begin
                    acc_d   = mm_r;
                    state_d = (bit_q == '0) ? FINISH : SQ_ISSUE;
                end
            end
            FINISH: begin
                result_d = acc_q;
                error_d  = err_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            exp_q      <= '0;
            mod_q      <= '0;
            acc_q      <= '0;
            bit_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            result_q   <= '0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_n_q     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q    <= state_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            mod_q      <= mod_d;
            acc_q      <= acc_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
            done_q     <= done_d;
            error_q    <= error_d;
            result_q   <= result_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_n_q     <= mm_n_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign error    = error_q;
    assign result   = result_q;
    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_n     = mm_n_q;

`ifdef MODEXP_PERF_CNT_EN
    logic [15:0] ops_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops_q <= '0;
        end else if (state_q == IDLE && start) begin
            ops_q <= '0;
        end else if (mm_start_d && ops_q != 16'hFFFF) begin
            ops_q <= ops_q + 16'd1;
        end
    end

    assign mm_ops = ops_q;
`endif

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencer for the 128-bit interleaved modular multiplier.
- Computes result = base^exponent mod modulus by left-to-right binary square-and-multiply.
- Issues one multiplier operation at a time and holds its operands stable. Sits between the host register interface and the multiplier instance.

Parameters:
- WIDTH, 128: width of base, modulus, result and multiplier operands.
- EXP_WIDTH, 128: exponent width; bit-index counters are $clog2(EXP_WIDTH)+1 bits wide.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; inputs are sampled on the same edge.
- base  in  WIDTH  must be < modulus.
- exponent  in  EXP_WIDTH  exponent.
- modulus  in  WIDTH  odd or even, nonzero.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- error  out  1  registered with done; set when modulus==0 or base>=modulus.
- result  out  WIDTH  holds the last answer until the next done.
- mm_start  out  1  one-cycle launch pulse to the multiplier.
- mm_a, mm_b, mm_n  out  WIDTH  multiplier operands; stable from mm_start until mm_done.
- mm_done  in  1  one-cycle completion pulse from the multiplier.
- mm_r  in  WIDTH  multiplier product; valid when mm_done is high.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE.
  - busy, done, error and mm_start are 0.
  - result=0; mm_a, mm_b and mm_n are 0.
- IDLE:
  - On start, latch base, exponent and modulus into shadow registers.
  - If modulus==0 or base>=modulus, go to FINISH with error=1 and result=0.
  - Otherwise go to SCAN.
  - start while busy is ignored.
- SCAN: find the highest set exponent bit idx in one cycle with the priority encoder.
  - exponent==0: acc = (modulus==1) ? 0 : 1, then go to FINISH.
  - Otherwise: acc=base, bit=idx. Go to FINISH if idx==0, else to SQ_ISSUE.
- SQ_ISSUE:
  - mm_a=acc, mm_b=acc, mm_n=modulus, mm_start=1 for this cycle only.
  - bit decrements here; go to SQ_WAIT.
- SQ_WAIT: on mm_done, acc<=mm_r.
  - If exponent[bit]==1, go to MUL_ISSUE.
  - Else go to FINISH if bit==0, otherwise to SQ_ISSUE.
- MUL_ISSUE: mm_a=acc, mm_b=base, mm_n=modulus, mm_start=1; go to MUL_WAIT.
- MUL_WAIT: on mm_done, acc<=mm_r. Go to FINISH if bit==0, else to SQ_ISSUE.
- FINISH: result<=acc, done=1 for one cycle, busy=0, then IDLE. A new start is accepted in the following cycle.
- Multiplier handshake:
  - mm_done outside a WAIT state is ignored.
  - mm_done in the same cycle as mm_start is ignored; the controller waits at least one cycle.
- Operation count: squares = idx; multiplies = popcount(exponent)-1; latency is the sum of multiplier latencies plus 3 + 2 per operation cycles.
- Reset mid-operation aborts immediately. The multiplier is not signalled; it is reset by the same reset.
- All arithmetic is done in the multiplier. The controller only compares (base>=modulus, modulus==0, modulus==1).

Optional Feature:
- Macro: MODEXP_PERF_CNT_EN.
- When defined:
  - Adds output mm_ops (16 bits): count of mm_start pulses in the current or last operation.
  - Cleared on an accepted start, saturates at 16'hFFFF, reset value 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package modexp_pkg holds:
  - the state enum: IDLE, SCAN, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FINISH;
  - WIDTH and EXP_WIDTH defaults;
  - the index-width localparam function.
- One sub-module, msb_find: a combinational priority encoder giving idx and a zero flag for EXP_WIDTH bits. The FSM stays in modexp_ctrl.

Test Plan:
(The bench uses a behavioural multiplier returning a*b mod n after a random 3-20 cycle delay.)
- base=4, exponent=13, modulus=497 -> result=445, error=0, exactly 5 mm_start pulses (3 squares, 2 multiplies); mm_ops=5 with the macro.
- base=7, exponent=1, modulus=11 -> result=7, zero mm_start pulses, done within 3 cycles of start.
- exponent=0, modulus=497 -> result=1; exponent=0, modulus=1, base=0 -> result=0.
- modulus=0 or base=500 with modulus=497 -> done with error=1, result=0, no mm_start.
- start pulsed again while busy (base=2, exponent=10, modulus=1000) -> second start ignored, result=24. Spurious mm_done in IDLE -> no state change.
- reset asserted during SQ_WAIT -> busy, done and mm_start go 0 asynchronously. A following start with 3^5 mod 7 -> result=5.
